// File: rtl/jenc_queue_pkg.sv
// jenc_queue shared definitions.
// Default geometry, thresholds and the LEVEL width helper.
package jenc_queue_pkg;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_DEPTH     = 64;
    localparam int unsigned DEF_AF_THRESH = 60;
    localparam int unsigned DEF_AE_THRESH = 4;

    // LEVEL must represent 0..DEPTH inclusive.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/jenc_queue_mem.sv
// jenc_queue storage array.
// One synchronous write port, one asynchronous read port, never reset.
module jenc_queue_mem
    import jenc_queue_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed word; contents are only validated by pointers.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jenc_queue_p.sv
// jenc_queue_p: show-ahead synchronous queue.
// Pointers, occupancy, status decode and sticky error flags.
module jenc_queue_p
    import jenc_queue_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEF_AF_THRESH,
    parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      PUSH_REQ,
    input  logic [WIDTH-1:0]          PUSH_DATA,
    input  logic                      POP_REQ,
    output logic [WIDTH-1:0]          POP_DATA,
    input  logic                      FLUSH,
    input  logic                      CLR_ERR,
    output logic                      FULL,
    output logic                      EMPTY,
    output logic                      ALMOST_FULL,
    output logic                      ALMOST_EMPTY,
    output logic [lvl_w(DEPTH)-1:0]   LEVEL,
    output logic                      OVERFLOW,
    output logic                      UNDERFLOW
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = lvl_w(DEPTH);

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;
    logic             ovf_evt;
    logic             unf_evt;
    logic [WIDTH-1:0] rd_data;

    // Status is decoded from the registered occupancy only.
    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);

    // A full queue drops the push even when a pop frees a slot.
    assign push_ok = PUSH_REQ & ~full  & ~FLUSH;
    assign pop_ok  = POP_REQ  & ~empty & ~FLUSH;
    assign ovf_evt = PUSH_REQ &  full  & ~FLUSH;
    assign unf_evt = POP_REQ  &  empty & ~FLUSH;

    jenc_queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (CLK),
        .we_i    (push_ok),
        .waddr_i (wp_q),
        .wdata_i (PUSH_DATA),
        .raddr_i (rp_q),
        .rdata_o (rd_data)
    );

    // Next pointers, occupancy and sticky flags.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (FLUSH) begin
            wp_d    = '0;
            rp_d    = '0;
            level_d = '0;
        end else begin
            if (push_ok) begin
                wp_d = wp_q + AW'(1);
            end
            if (pop_ok) begin
                rp_d = rp_q + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (CLR_ERR) begin
            ovf_d = 1'b0;
        end

        if (unf_evt) begin
            unf_d = 1'b1;
        end else if (CLR_ERR) begin
            unf_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign POP_DATA     = empty ? '0 : rd_data;
    assign FULL         = full;
    assign EMPTY        = empty;
    assign ALMOST_FULL  = (level_q >= LVL_AF);
    assign ALMOST_EMPTY = (level_q <= LVL_AE);
    assign LEVEL        = level_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule
